// File: rtl/core_pkg.sv
// Shared definitions for the 16-bit pipelined core: datapath defaults and
// the branch condition-code encodings.
package core_pkg;

   localparam int DW_DEFAULT = 16;
   localparam int RW_DEFAULT = 4;

   typedef logic [2:0] cc_t;

   localparam cc_t CC_NE = 3'b000;
   localparam cc_t CC_EQ = 3'b001;
   localparam cc_t CC_GT = 3'b010;
   localparam cc_t CC_LT = 3'b011;
   localparam cc_t CC_GE = 3'b100;
   localparam cc_t CC_LE = 3'b101;
   localparam cc_t CC_OV = 3'b110;
   localparam cc_t CC_UN = 3'b111;

endpackage

// File: rtl/br_cond.sv
// Pure combinational branch-condition evaluator: decides whether condition
// code i_cc holds for the given V/Z/N flags.
module br_cond
   import core_pkg::*;
(
   input  logic [2:0] i_cc,
   input  logic       i_V,
   input  logic       i_Z,
   input  logic       i_N,
   output logic       o_true
);

   always_comb begin
      o_true = 1'b0;
      case (i_cc)
         CC_NE:   o_true = ~i_Z;
         CC_EQ:   o_true = i_Z;
         CC_GT:   o_true = ~i_Z & ~i_N;
         CC_LT:   o_true = i_N;
         CC_GE:   o_true = i_Z | ~i_N;
         CC_LE:   o_true = i_Z | i_N;
         CC_OV:   o_true = i_V;
         CC_UN:   o_true = 1'b1;
         default: o_true = 1'b0;
      endcase
   end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline boundary: latches EX results into the memory stage, owns
// the V/Z/N condition codes and resolves branches/jumps one cycle after EX.
module ex_mem_stage
   import core_pkg::*;
#(
   parameter int DW = DW_DEFAULT,
   parameter int RW = RW_DEFAULT
)
(
   input  logic          clk,
   input  logic          rst,
   input  logic          stall,

   input  logic          ex_valid,
   input  logic [DW-1:0] ex_aluResult,
   input  logic          ex_V,
   input  logic          ex_Z,
   input  logic          ex_N,
   input  logic [DW-1:0] ex_addResult,
   input  logic [DW-1:0] ex_jumpTo,
   input  logic [DW-1:0] ex_p1,
   input  logic [DW-1:0] ex_pcPlus1,
   input  logic [RW-1:0] ex_dst,
   input  logic          ex_regWe,
   input  logic          ex_memRe,
   input  logic          ex_memWe,
   input  logic          ex_zWe,
   input  logic          ex_nvWe,
   input  logic          ex_isBr,
   input  logic [2:0]    ex_cc,
   input  logic          ex_isJmp,
   input  logic          ex_isJr,
   input  logic          ex_isJal,
   input  logic          ex_hlt,

   output logic          mem_valid,
   output logic [DW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic [DW-1:0] mem_wbData,
   output logic [RW-1:0] mem_dst,
   output logic          mem_regWe,
   output logic          mem_memRe,
   output logic          mem_memWe,
   output logic          mem_hlt,

   output logic          flagV,
   output logic          flagZ,
   output logic          flagN,

   output logic          redirect,
   output logic [DW-1:0] redirectPC,
   output logic          flush
);

   logic          r_valid;
   logic [DW-1:0] r_addr;
   logic [DW-1:0] r_wdata;
   logic [DW-1:0] r_wbData;
   logic [RW-1:0] r_dst;
   logic          r_regWe;
   logic          r_memRe;
   logic          r_memWe;
   logic          r_hlt;

   logic          r_flagV;
   logic          r_flagZ;
   logic          r_flagN;

   logic          r_brPend;
   logic [2:0]    r_brCc;
   logic [DW-1:0] r_brTarget;

   logic          w_condTrue;
   logic          w_taken;
   logic          w_squash;
   logic          w_capValid;
   logic          w_exIsXfer;
   logic          w_exIsJump;

   // A redirect squashes whatever sits in EX on the same edge, so the
   // younger instruction is captured as a bubble and cannot touch the flags.
   always_comb begin
      w_exIsJump = ex_isJmp | ex_isJr;
      w_exIsXfer = ex_isBr | w_exIsJump;
      w_capValid = ex_valid & ~w_squash;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid  <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_wbData <= '0;
         r_dst    <= '0;
         r_regWe  <= 1'b0;
         r_memRe  <= 1'b0;
         r_memWe  <= 1'b0;
         r_hlt    <= 1'b0;
      end else if (!stall) begin
         r_valid  <= w_capValid;
         r_addr   <= ex_aluResult;
         r_wdata  <= ex_p1;
         r_wbData <= ex_isJal ? ex_pcPlus1 : ex_aluResult;
         r_dst    <= ex_dst;
         r_regWe  <= w_capValid & ex_regWe;
         r_memRe  <= w_capValid & ex_memRe;
         r_memWe  <= w_capValid & ex_memWe;
         r_hlt    <= w_capValid & ex_hlt;
      end
   end

   // Jumps are stored with the always-true code so resolution is uniform.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_brPend   <= 1'b0;
         r_brCc     <= CC_NE;
         r_brTarget <= '0;
      end else if (!stall) begin
         r_brPend   <= w_capValid & w_exIsXfer;
         r_brCc     <= w_exIsJump ? CC_UN : ex_cc;
         r_brTarget <= ex_isJr ? ex_aluResult : (ex_isJmp ? ex_jumpTo : ex_addResult);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_flagV <= 1'b0;
         r_flagZ <= 1'b0;
         r_flagN <= 1'b0;
      end else if (!stall && w_capValid) begin
         if (ex_zWe) begin
            r_flagZ <= ex_Z;
         end
         if (ex_nvWe) begin
            r_flagN <= ex_N;
            r_flagV <= ex_V;
         end
      end
   end

   br_cond u_brCond (
      .i_cc   (r_brCc),
      .i_V    (r_flagV),
      .i_Z    (r_flagZ),
      .i_N    (r_flagN),
      .o_true (w_condTrue)
   );

   always_comb begin
      w_taken  = r_brPend & w_condTrue;
      redirect = w_taken & ~stall;
      flush    = redirect;
      w_squash = redirect;
   end

   assign redirectPC = r_brTarget;

   assign mem_valid  = r_valid;
   assign mem_addr   = r_addr;
   assign mem_wdata  = r_wdata;
   assign mem_wbData = r_wbData;
   assign mem_dst    = r_dst;
   assign mem_regWe  = r_regWe;
   assign mem_memRe  = r_memRe;
   assign mem_memWe  = r_memWe;
   assign mem_hlt    = r_hlt;

   assign flagV = r_flagV;
   assign flagZ = r_flagZ;
   assign flagN = r_flagN;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: stimulus pushes expected captures and
// redirects, independent monitors pop and compare them.
module tb_ex_mem_stage;
   import core_pkg::*;

   localparam int DW = 16;
   localparam int RW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          stall;
   logic          ex_valid;
   logic [DW-1:0] ex_aluResult;
   logic          ex_V, ex_Z, ex_N;
   logic [DW-1:0] ex_addResult;
   logic [DW-1:0] ex_jumpTo;
   logic [DW-1:0] ex_p1;
   logic [DW-1:0] ex_pcPlus1;
   logic [RW-1:0] ex_dst;
   logic          ex_regWe, ex_memRe, ex_memWe;
   logic          ex_zWe, ex_nvWe;
   logic          ex_isBr;
   logic [2:0]    ex_cc;
   logic          ex_isJmp, ex_isJr, ex_isJal, ex_hlt;

   logic          mem_valid;
   logic [DW-1:0] mem_addr, mem_wdata, mem_wbData;
   logic [RW-1:0] mem_dst;
   logic          mem_regWe, mem_memRe, mem_memWe, mem_hlt;
   logic          flagV, flagZ, flagN;
   logic          redirect;
   logic [DW-1:0] redirectPC;
   logic          flush;

   always #5 clk = ~clk;

   ex_mem_stage #(.DW(DW), .RW(RW)) dut (
      .clk          (clk),
      .rst          (rst),
      .stall        (stall),
      .ex_valid     (ex_valid),
      .ex_aluResult (ex_aluResult),
      .ex_V         (ex_V),
      .ex_Z         (ex_Z),
      .ex_N         (ex_N),
      .ex_addResult (ex_addResult),
      .ex_jumpTo    (ex_jumpTo),
      .ex_p1        (ex_p1),
      .ex_pcPlus1   (ex_pcPlus1),
      .ex_dst       (ex_dst),
      .ex_regWe     (ex_regWe),
      .ex_memRe     (ex_memRe),
      .ex_memWe     (ex_memWe),
      .ex_zWe       (ex_zWe),
      .ex_nvWe      (ex_nvWe),
      .ex_isBr      (ex_isBr),
      .ex_cc        (ex_cc),
      .ex_isJmp     (ex_isJmp),
      .ex_isJr      (ex_isJr),
      .ex_isJal     (ex_isJal),
      .ex_hlt       (ex_hlt),
      .mem_valid    (mem_valid),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_wbData   (mem_wbData),
      .mem_dst      (mem_dst),
      .mem_regWe    (mem_regWe),
      .mem_memRe    (mem_memRe),
      .mem_memWe    (mem_memWe),
      .mem_hlt      (mem_hlt),
      .flagV        (flagV),
      .flagZ        (flagZ),
      .flagN        (flagN),
      .redirect     (redirect),
      .redirectPC   (redirectPC),
      .flush        (flush)
   );

   typedef struct {
      logic          valid;
      logic [DW-1:0] alu;
      logic          v, z, n, zWe, nvWe;
      logic [DW-1:0] add, jmp, p1, pc1;
      logic [RW-1:0] dst;
      logic          regWe, memRe, memWe, isBr;
      logic [2:0]    cc;
      logic          isJmp, isJr, isJal, hlt;
   } instr_t;

   typedef struct {
      logic [DW-1:0] addr, wdata, wbData;
      logic [RW-1:0] dst;
      logic          regWe, memRe, memWe, hlt;
      logic          v, z, n;
   } memExp_t;

   memExp_t       memQ[$];
   logic [DW-1:0] redQ[$];
   int            assertCount = 0;
   int            failCount   = 0;
   logic          expV = 1'b0, expZ = 1'b0, expN = 1'b0;

   // Pattern index p -> flags (V,Z,N): 0:000 1:010 2:001 3:100.
   // Bit p of takenTab[cc] is whether that condition holds for pattern p.
   logic [3:0] takenTab [8];
   logic       patV [4];
   logic       patZ [4];
   logic       patN [4];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      assertCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic instr_t blankI();
      instr_t i;
      i.valid = 1'b0; i.alu = '0; i.v = 1'b0; i.z = 1'b0; i.n = 1'b0;
      i.zWe = 1'b0; i.nvWe = 1'b0; i.add = '0; i.jmp = '0; i.p1 = '0; i.pc1 = '0;
      i.dst = '0; i.regWe = 1'b0; i.memRe = 1'b0; i.memWe = 1'b0; i.isBr = 1'b0;
      i.cc = 3'b000; i.isJmp = 1'b0; i.isJr = 1'b0; i.isJal = 1'b0; i.hlt = 1'b0;
      return i;
   endfunction

   function automatic instr_t nopI(input logic [DW-1:0] a);
      instr_t i = blankI();
      i.valid = 1'b1; i.alu = a; i.pc1 = a + 16'h0100;
      return i;
   endfunction

   function automatic instr_t aluI(input logic [DW-1:0] res, input logic v, z, n, zWe, nvWe,
                                  input logic [RW-1:0] dst);
      instr_t i = nopI(res);
      i.v = v; i.z = z; i.n = n; i.zWe = zWe; i.nvWe = nvWe; i.dst = dst; i.regWe = 1'b1;
      return i;
   endfunction

   function automatic instr_t brI(input logic [2:0] cc, input logic [DW-1:0] tgt);
      instr_t i = nopI(16'hBEEF);
      i.isBr = 1'b1; i.cc = cc; i.add = tgt; i.jmp = 16'hDEAD;
      return i;
   endfunction

   function automatic instr_t jmpI(input logic [DW-1:0] tgt);
      instr_t i = nopI(16'h0555);
      i.isJmp = 1'b1; i.jmp = tgt; i.add = 16'h0999; i.cc = CC_NE;
      return i;
   endfunction

   function automatic instr_t jrI(input logic [DW-1:0] tgt);
      instr_t i = nopI(tgt);
      i.isJr = 1'b1; i.add = 16'h0777; i.jmp = 16'h0888; i.cc = CC_EQ;
      return i;
   endfunction

   task automatic drive(input instr_t i);
      ex_valid = i.valid; ex_aluResult = i.alu; ex_V = i.v; ex_Z = i.z; ex_N = i.n;
      ex_zWe = i.zWe; ex_nvWe = i.nvWe; ex_addResult = i.add; ex_jumpTo = i.jmp;
      ex_p1 = i.p1; ex_pcPlus1 = i.pc1; ex_dst = i.dst; ex_regWe = i.regWe;
      ex_memRe = i.memRe; ex_memWe = i.memWe; ex_isBr = i.isBr; ex_cc = i.cc;
      ex_isJmp = i.isJmp; ex_isJr = i.isJr; ex_isJal = i.isJal; ex_hlt = i.hlt;
   endtask

   // Presents one instruction for one unstalled edge; expectation is queued first.
   task automatic applyStimulus(input instr_t i, input bit squashed);
      memExp_t e;
      drive(i);
      if (i.valid && !squashed) begin
         if (i.zWe) expZ = i.z;
         if (i.nvWe) begin
            expN = i.n;
            expV = i.v;
         end
         e.addr = i.alu; e.wdata = i.p1; e.wbData = i.isJal ? i.pc1 : i.alu; e.dst = i.dst;
         e.regWe = i.regWe; e.memRe = i.memRe; e.memWe = i.memWe; e.hlt = i.hlt;
         e.v = expV; e.z = expZ; e.n = expN;
         memQ.push_back(e);
      end
      @(posedge clk);
      #2;
   endtask

   // Capture monitor.
   initial begin
      logic capStall, capRst;
      memExp_t e;
      forever begin
         @(posedge clk);
         capStall = stall;
         capRst   = rst;
         #1;
         if (!capRst && !capStall && mem_valid) begin
            if (memQ.size() == 0) begin
               assertCount++;
               failCount++;
               $display("[TB] FAIL memUnexpected: got valid capture addr 0x%0h, expected none at %0t", mem_addr, $time);
            end else begin
               e = memQ.pop_front();
               checkOutput("memAddr",   32'(mem_addr),   32'(e.addr));
               checkOutput("memWdata",  32'(mem_wdata),  32'(e.wdata));
               checkOutput("memWbData", 32'(mem_wbData), 32'(e.wbData));
               checkOutput("memCtrl", 32'({mem_dst, mem_regWe, mem_memRe, mem_memWe, mem_hlt}),
                           32'({e.dst, e.regWe, e.memRe, e.memWe, e.hlt}));
               checkOutput("flagsVZN", 32'({flagV, flagZ, flagN}), 32'({e.v, e.z, e.n}));
            end
         end
      end
   end

   // Redirect monitor, sampled mid-cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (stall) begin
               checkOutput("redirectInStall", 32'(redirect), 32'd0);
               checkOutput("flushInStall", 32'(flush), 32'd0);
            end else if (redirect) begin
               checkOutput("flushWithRedirect", 32'(flush), 32'd1);
               if (redQ.size() == 0) begin
                  assertCount++;
                  failCount++;
                  $display("[TB] FAIL redirectUnexpected: got redirect to 0x%0h, expected none at %0t", redirectPC, $time);
               end else begin
                  checkOutput("redirectPC", 32'(redirectPC), 32'(redQ.pop_front()));
               end
            end
         end
      end
   end

   initial begin
      instr_t i;
      logic [DW-1:0] tgt;
      bit tk;

      takenTab = '{4'hD, 4'h2, 4'h9, 4'h4, 4'hB, 4'h6, 4'h8, 4'hF};
      patV = '{1'b0, 1'b0, 1'b0, 1'b1};
      patZ = '{1'b0, 1'b1, 1'b0, 1'b0};
      patN = '{1'b0, 1'b0, 1'b1, 1'b0};

      // Reset with garbage on the EX side.
      rst = 1'b1;
      stall = 1'b0;
      for (int c = 0; c < 2; c++) begin
         ex_valid = 1'b1; ex_aluResult = 16'($urandom); ex_V = 1'b1; ex_Z = 1'b1; ex_N = 1'b1;
         ex_zWe = 1'b1; ex_nvWe = 1'b1; ex_addResult = 16'($urandom); ex_jumpTo = 16'($urandom);
         ex_p1 = 16'($urandom); ex_pcPlus1 = 16'($urandom); ex_dst = 4'($urandom);
         ex_regWe = 1'b1; ex_memRe = 1'b1; ex_memWe = 1'b1; ex_isBr = 1'b1; ex_cc = CC_UN;
         ex_isJmp = 1'b1; ex_isJr = 1'b0; ex_isJal = 1'b1; ex_hlt = 1'b1;
         @(posedge clk);
         #2;
      end
      checkOutput("rstMemValid", 32'(mem_valid), 32'd0);
      checkOutput("rstMemData", 32'({mem_addr, mem_wdata}), 32'd0);
      checkOutput("rstWbData", 32'(mem_wbData), 32'd0);
      checkOutput("rstCtrl", 32'({mem_dst, mem_regWe, mem_memRe, mem_memWe, mem_hlt}), 32'd0);
      checkOutput("rstFlags", 32'({flagV, flagZ, flagN}), 32'd0);
      checkOutput("rstRedirect", 32'({redirect, flush}), 32'd0);
      drive(blankI());
      rst = 1'b0;
      #4;
      checkOutput("postRstRedirect", 32'({redirect, flush}), 32'd0);
      applyStimulus(blankI(), 0);

      // Flag gating: SUB sets Z, AND clears Z while N/V stay.
      applyStimulus(aluI(16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd1), 0);
      applyStimulus(aluI(16'h00F0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2), 0);

      // Taken BEQ; younger instruction squashed and its flag write blocked.
      applyStimulus(aluI(16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd3), 0);
      redQ.push_back(16'h0040);
      applyStimulus(brI(CC_EQ, 16'h0040), 0);
      applyStimulus(aluI(16'h5555, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'd4), 1);
      i = nopI(16'h0010); i.memWe = 1'b1; i.p1 = 16'hA5A5;
      applyStimulus(i, 0);

      // Not-taken BEQ: no bubble.
      applyStimulus(aluI(16'h0001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd5), 0);
      applyStimulus(brI(CC_EQ, 16'h0080), 0);
      i = aluI(16'h0020, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd6); i.memRe = 1'b1;
      applyStimulus(i, 0);

      // JAL: linked writeback value and redirect to the jump target.
      i = jmpI(16'h0300); i.isJal = 1'b1; i.pc1 = 16'h0021; i.regWe = 1'b1; i.dst = 4'd15;
      redQ.push_back(16'h0300);
      applyStimulus(i, 0);
      applyStimulus(nopI(16'h0011), 1);
      applyStimulus(nopI(16'h0012), 0);

      // JR held in MEM by a 3-cycle stall; a halt waits in EX and gets squashed.
      applyStimulus(aluI(16'h0002, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'd7), 0);
      redQ.push_back(16'h1234);
      applyStimulus(jrI(16'h1234), 0);
      i = nopI(16'h0042); i.hlt = 1'b1; i.zWe = 1'b1; i.z = 1'b1;
      drive(i);
      stall = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #2;
         checkOutput("stallHoldAddr", 32'({mem_valid, mem_addr}), 32'({1'b1, 16'h1234}));
         checkOutput("stallHoldFlags", 32'({flagV, flagZ, flagN}), 32'({expV, expZ, expN}));
      end
      stall = 1'b0;
      applyStimulus(i, 1);
      applyStimulus(nopI(16'h0013), 0);
      checkOutput("haltDropped", 32'(mem_hlt), 32'd0);

      // Back-to-back: JMP then BNE (would be taken); only the JMP redirects.
      applyStimulus(aluI(16'h0003, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd8), 0);
      redQ.push_back(16'h0100);
      applyStimulus(jmpI(16'h0100), 0);
      applyStimulus(brI(CC_NE, 16'h0200), 1);
      applyStimulus(nopI(16'h0014), 0);
      applyStimulus(nopI(16'h0015), 0);

      // Every condition code against four flag patterns.
      for (int cc = 0; cc < 8; cc++) begin
         for (int p = 0; p < 4; p++) begin
            applyStimulus(aluI(16'h1000 + 16'(cc * 4 + p), patV[p], patZ[p], patN[p], 1'b1, 1'b1, 4'd9), 0);
            tk  = takenTab[cc][p];
            tgt = 16'h2000 + 16'(cc * 16 + p);
            if (tk) redQ.push_back(tgt);
            applyStimulus(brI(3'(cc), tgt), 0);
            applyStimulus(aluI(16'h7777, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd10), tk);
            applyStimulus(nopI(16'h0016), 0);
         end
      end

      for (int c = 0; c < 4; c++) applyStimulus(blankI(), 0);
      checkOutput("memQueueDrained", 32'(memQ.size()), 32'd0);
      checkOutput("redirectQueueDrained", 32'(redQ.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- EX/MEM pipeline boundary of the 16-bit pipelined core. Sits directly downstream of the execute stage.
- Latches the ALU result, branch/jump targets, store data and control bits into the memory stage.
- Owns the architectural V/Z/N condition-code register.
- Resolves branches and jumps one cycle after EX. Drives the PC redirect and the flush of all younger instructions.

Parameters:
- DW, 16, datapath width
- RW, 4, register-index width

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- stall  in  1  memory stage busy; hold all state
- ex_valid  in  1  EX holds a real instruction
- ex_aluResult  in  DW  ALU output
- ex_V, ex_Z, ex_N  in  1 each  ALU flags
- ex_addResult  in  DW  branch target
- ex_jumpTo  in  DW  jump target
- ex_p1  in  DW  store data
- ex_pcPlus1  in  DW  link value
- ex_dst  in  RW  destination register
- ex_regWe, ex_memRe, ex_memWe  in  1 each  writeback and memory controls
- ex_zWe  in  1  update Z
- ex_nvWe  in  1  update N and V
- ex_isBr  in  1  conditional branch
- ex_cc  in  3  branch condition
- ex_isJmp  in  1  PC-relative jump
- ex_isJr  in  1  register jump; target is ex_aluResult
- ex_isJal  in  1  link; writeback value is pcPlus1
- ex_hlt  in  1  halt
- mem_valid  out  1  latched valid
- mem_addr  out  DW  latched aluResult
- mem_wdata  out  DW  latched p1
- mem_wbData  out  DW  pcPlus1 if link, else aluResult
- mem_dst  out  RW  latched destination
- mem_regWe, mem_memRe, mem_memWe, mem_hlt  out  1 each  latched controls; all gated by valid
- flagV, flagZ, flagN  out  1 each  condition-code register
- redirect  out  1  PC redirect
- redirectPC  out  DW  new PC
- flush  out  1  kill IF/ID and ID/EX this cycle

Behaviour:
- Reset, synchronous:
  - All mem_* outputs and flags become 0.
  - Internal branch-pending state is cleared.
  - redirect and flush are 0 in the cycle after reset.
- Capture (rising edge, rst=0, stall=0):
  - All mem_* registers load from ex_*.
  - mem_valid = ex_valid & ~squash.
  - Controls are ANDed with the captured valid.
  - Internal brPend, brCc, brTarget load alongside:
    - brPend = valid & (isBr|isJmp|isJr).
    - brTarget = isJr ? aluResult : isJmp ? jumpTo : addResult.
- Flag register: written at the same edge as capture, only if the captured valid=1.
  - Z updates when zWe=1.
  - N and V update when nvWe=1.
  - Otherwise the flags hold.
  - Branches never write flags, so a branch in MEM sees the flags of the instruction ahead of it.
- Stall=1: every register holds, including the flags. redirect and flush are forced to 0.
- Resolution, combinational from registered state:
  - taken = brPend & (jump | condTrue(brCc, flags)).
  - Condition codes:
    - 000 NE: ~Z
    - 001 EQ: Z
    - 010 GT: ~Z&~N
    - 011 LT: N
    - 100 GE: Z|~N
    - 101 LE: Z|N
    - 110 OV: V
    - 111 UN: 1
  - Jumps carry cc=111 internally.
- redirect = flush = taken & ~stall.
- redirectPC = brTarget.
- squash = redirect. The instruction presently in EX is captured as invalid, so mem_valid=0 and it writes no flags.
- Predicted not-taken: a not-taken branch produces no bubble. A taken branch costs 3 squashed instructions (IF, ID, EX).
- Back-to-back branches: the second one is squashed by the first's redirect. Only one redirect issues.
- A halt captured in the same edge as a squash is dropped.
- rst mid-stall or mid-redirect: reset wins and all state clears.
- No arithmetic performed here. All widths pass through unchanged.

Decomposition:
- Shared package core_pkg holds:
  - The cc encodings CC_NE..CC_UN.
  - DW/RW defaults.
- One natural sub-module: br_cond, a pure combinational condition evaluator (cc, V, Z, N -> true). The verification engineer can test it exhaustively (8x8 combinations).

Test Plan:
- Reset: hold rst 2 cycles with random ex_* inputs -> all outputs 0, flags 000, redirect 0.
- Flag gating:
  - SUB with aluResult=0x0000, Z=1, N=0, zWe=nvWe=1 -> flagZ=1.
  - Next an AND with zWe=1, nvWe=0, Z=0, N=1 -> flagZ=0, flagN stays 0.
- Taken branch: flags Z=1, then BEQ (cc=001) with addResult=0x0040 -> the cycle after capture, redirect=1 and redirectPC=0x0040. The instruction captured on that edge has mem_valid=0, and its flag write is blocked.
- Not-taken: flags Z=0, BEQ -> redirect stays 0, no squash, and the next instruction has mem_valid=1.
- Stall interaction: taken JR (aluResult=0x1234) enters MEM while stall=1 for 3 cycles -> redirect=0 throughout, flags and mem_* hold. On the first cycle with stall=0, redirect=1 and redirectPC=0x1234, exactly once.
- Back-to-back: unconditional JMP to 0x0100 followed immediately by BNE to 0x0200 -> a single redirect to 0x0100. The BNE is squashed and never redirects.
